// File: rtl/gpio_periph_pkg.sv
// ============================================================================
//  Module   : gpio_periph_pkg
//  Purpose  : Shared sizes and the hex-to-7-segment encoding table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package gpio_periph_pkg;
   localparam int NUM_DIGITS = 8;
   localparam int SW_W       = 18;
   localparam int KEY_W      = 4;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   // Active-low {g,f,e,d,c,b,a}; element 15 (F) first, element 0 (0) last.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };
endpackage

`default_nettype wire

// File: rtl/gpio_periph_hex7seg.sv
// ============================================================================
//  Module   : hex7seg
//  Purpose  : Combinational nibble to active-low seven-segment decode.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hex7seg
   import gpio_periph_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);
   always_comb begin
      seg_n = SEG_TABLE[nibble];
   end
endmodule

`default_nettype wire

// File: rtl/gpio_periph.sv
// ============================================================================
//  Module   : gpio_periph
//  Purpose  : Switch/key input conditioning for the CPU plus a multiplexed
//             8-digit hex display of the CPU GPIO output word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gpio_periph
   import gpio_periph_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SCAN_DIV        = 50000
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SW_W-1:0]       sw,
   input  logic [KEY_W-1:0]      key_n,
   input  logic [31:0]           cpu_gpio_out,
   output logic [31:0]           cpu_gpio_in,
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] dig_sel_n
);
   localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] DIG_ONE    = NUM_DIGITS'(1);

   logic [SW_W-1:0]             sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
   logic [KEY_W-1:0]            key_meta_q, key_meta_d, key_sync_q, key_sync_d;
   logic [KEY_W-1:0]            key_stable_q, key_stable_d;
   logic [KEY_W-1:0][CNT_W-1:0] key_cnt_q, key_cnt_d;
   logic [31:0]                 cpu_gpio_in_q, cpu_gpio_in_d;
   logic [PRESC_W-1:0]          presc_q, presc_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [31:0]                 snapshot_q, snapshot_d;
   logic                        first_q, first_d;
   logic [6:0]                  seg_n_q, seg_n_d;
   logic [NUM_DIGITS-1:0]       dig_sel_n_q, dig_sel_n_d;
   logic                        presc_wrap;
   logic [3:0]                  cur_nibble;
   logic [6:0]                  cur_seg_n;

   hex7seg u_hex7seg (
      .nibble (cur_nibble),
      .seg_n  (cur_seg_n)
   );

   always_comb begin
      sw_meta_d    = sw;
      sw_sync_d    = sw_meta_q;
      key_meta_d   = key_n;
      key_sync_d   = key_meta_q;
      key_stable_d = key_stable_q;
      key_cnt_d    = key_cnt_q;

      // A key must disagree with its stable value for DEBOUNCE_CYCLES
      // consecutive cycles; any agreeing cycle restarts the count.
      for (int i = 0; i < KEY_W; i++) begin
         if (key_sync_q[i] == key_stable_q[i]) begin
            key_cnt_d[i] = '0;
         end else if (key_cnt_q[i] == CNT_LAST) begin
            key_stable_d[i] = key_sync_q[i];
            key_cnt_d[i]    = '0;
         end else begin
            key_cnt_d[i] = key_cnt_q[i] + CNT_W'(1);
         end
      end

      cpu_gpio_in_d = {{(32 - KEY_W - SW_W){1'b0}}, ~key_stable_q, sw_sync_q};
   end

   always_comb begin
      presc_wrap = (presc_q == PRESC_LAST);
      presc_d    = presc_wrap ? '0 : presc_q + PRESC_W'(1);
      idx_d      = presc_wrap ? idx_q + IDX_W'(1) : idx_q;
      first_d    = 1'b0;

      // Snapshot only at frame boundaries so a frame never mixes two words.
      if (first_q || (presc_wrap && (idx_q == IDX_LAST))) begin
         snapshot_d = cpu_gpio_out;
      end else begin
         snapshot_d = snapshot_q;
      end

      cur_nibble = snapshot_q[{idx_q, 2'b00} +: 4];

      // The snapshot is not valid until the first post-reset clock loads it.
      if (first_q) begin
         seg_n_d     = 7'h7F;
         dig_sel_n_d = '1;
      end else begin
         seg_n_d     = cur_seg_n;
         dig_sel_n_d = ~(DIG_ONE << idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta_q     <= '0;
         sw_sync_q     <= '0;
         key_meta_q    <= '1;
         key_sync_q    <= '1;
         key_stable_q  <= '1;
         key_cnt_q     <= '0;
         cpu_gpio_in_q <= '0;
         presc_q       <= '0;
         idx_q         <= '0;
         snapshot_q    <= '0;
         first_q       <= 1'b1;
         seg_n_q       <= 7'h7F;
         dig_sel_n_q   <= '1;
      end else begin
         sw_meta_q     <= sw_meta_d;
         sw_sync_q     <= sw_sync_d;
         key_meta_q    <= key_meta_d;
         key_sync_q    <= key_sync_d;
         key_stable_q  <= key_stable_d;
         key_cnt_q     <= key_cnt_d;
         cpu_gpio_in_q <= cpu_gpio_in_d;
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         snapshot_q    <= snapshot_d;
         first_q       <= first_d;
         seg_n_q       <= seg_n_d;
         dig_sel_n_q   <= dig_sel_n_d;
      end
   end

   assign cpu_gpio_in = cpu_gpio_in_q;
   assign seg_n       = seg_n_q;
   assign dig_sel_n   = dig_sel_n_q;
endmodule

`default_nettype wire

// File: tb/tb_gpio_periph.sv
// ============================================================================
//  Module   : tb_gpio_periph
//  Purpose  : Self-checking bench for gpio_periph with short debounce/scan.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gpio_periph;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] sw = '0;
   logic [3:0]  key_n = 4'hF;
   logic [31:0] cpu_gpio_out = '0;
   logic [31:0] cpu_gpio_in;
   logic [6:0]  seg_n;
   logic [7:0]  dig_sel_n;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_in_q[$];
   logic [14:0] exp_scan_q[$];

   localparam logic [17:0] SW_PAT = 18'h2A5A5;

   always #5 clk = ~clk;

   gpio_periph #(
      .DEBOUNCE_CYCLES (4),
      .SCAN_DIV        (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sw           (sw),
      .key_n        (key_n),
      .cpu_gpio_out (cpu_gpio_out),
      .cpu_gpio_in  (cpu_gpio_in),
      .seg_n        (seg_n),
      .dig_sel_n    (dig_sel_n)
   );

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Returns with the bench aligned on the first cycle of a digit-0 display.
   task automatic wait_frame_start(output bit ok);
      logic [7:0] prev;
      ok   = 1'b0;
      prev = dig_sel_n;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (prev == 8'h7F && dig_sel_n == 8'hFE) begin
            ok = 1'b1;
            break;
         end
         prev = dig_sel_n;
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if (cpu_gpio_in !== 32'h0) $display("FAIL reset_gpio_in: got %h expected %h", cpu_gpio_in, 32'h0);
      else n_pass++;
      n_checks++;
      if (seg_n !== 7'h7F) $display("FAIL reset_seg_n: got %h expected %h", seg_n, 7'h7F);
      else n_pass++;
      n_checks++;
      if (dig_sel_n !== 8'hFF) $display("FAIL reset_dig_sel_n: got %h expected %h", dig_sel_n, 8'hFF);
      else n_pass++;
      rst = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_switches();
      logic [31:0] exp;
      sw = SW_PAT;
      exp_in_q.push_back(32'h0);
      exp_in_q.push_back(32'h0);
      exp_in_q.push_back({14'h0, SW_PAT});
      for (int t = 1; t <= 3; t++) begin
         tick();
         exp = exp_in_q.pop_front();
         n_checks++;
         if (cpu_gpio_in !== exp) $display("FAIL sw_path t=%0d: got %h expected %h", t, cpu_gpio_in, exp);
         else n_pass++;
      end
   endtask

   task automatic test_key_press();
      logic [31:0] exp;
      for (int ph = 0; ph < 2; ph++) begin
         key_n[0] = (ph == 0) ? 1'b0 : 1'b1;
         for (int t = 1; t <= 7; t++) begin
            if (ph == 0) exp_in_q.push_back({10'h0, (t == 7) ? 4'b0001 : 4'b0000, SW_PAT});
            else         exp_in_q.push_back({10'h0, (t == 7) ? 4'b0000 : 4'b0001, SW_PAT});
         end
         for (int t = 1; t <= 7; t++) begin
            tick();
            exp = exp_in_q.pop_front();
            n_checks++;
            if (cpu_gpio_in !== exp)
               $display("FAIL key0_%s t=%0d: got %h expected %h", (ph == 0) ? "press" : "release", t, cpu_gpio_in, exp);
            else n_pass++;
         end
      end
   endtask

   task automatic test_key_glitch();
      logic [31:0] exp;
      // Two 3-cycle glitches separated by one released cycle must never register.
      for (int t = 0; t < 20; t++) begin
         key_n[1] = ((t < 3) || (t >= 4 && t < 7)) ? 1'b0 : 1'b1;
         exp_in_q.push_back({10'h0, 4'b0000, SW_PAT});
         tick();
         exp = exp_in_q.pop_front();
         n_checks++;
         if (cpu_gpio_in !== exp) $display("FAIL key1_glitch t=%0d: got %h expected %h", t, cpu_gpio_in, exp);
         else n_pass++;
      end
   endtask

   task automatic push_frame(input logic [31:0] word);
      for (int d = 0; d < 8; d++) begin
         for (int r = 0; r < 2; r++) begin
            exp_scan_q.push_back({~(8'h01 << d), seg_of(word[4*d +: 4])});
         end
      end
   endtask

   task automatic test_scan();
      bit ok;
      logic [14:0] exp;
      cpu_gpio_out = 32'h89ABCDEF;
      wait_frame_start(ok);
      n_checks++;
      if (!ok) begin
         $display("FAIL scan_align: got no frame start expected dig_sel_n 7F->FE");
         return;
      end
      n_pass++;
      push_frame(32'h89ABCDEF);
      for (int k = 0; k < 16; k++) begin
         exp = exp_scan_q.pop_front();
         n_checks++;
         if ({dig_sel_n, seg_n} !== exp)
            $display("FAIL scan_frame k=%0d: got %h/%h expected %h/%h", k, dig_sel_n, seg_n, exp[14:7], exp[6:0]);
         else n_pass++;
         tick();
      end
   endtask

   task automatic test_midframe();
      bit ok;
      logic [14:0] exp;
      cpu_gpio_out = 32'h89ABCDEF;
      wait_frame_start(ok);
      n_checks++;
      if (!ok) begin
         $display("FAIL midframe_align: got no frame start expected dig_sel_n 7F->FE");
         return;
      end
      n_pass++;
      push_frame(32'h89ABCDEF);
      push_frame(32'h0);
      for (int k = 0; k < 32; k++) begin
         exp = exp_scan_q.pop_front();
         n_checks++;
         if ({dig_sel_n, seg_n} !== exp)
            $display("FAIL midframe k=%0d: got %h/%h expected %h/%h", k, dig_sel_n, seg_n, exp[14:7], exp[6:0]);
         else n_pass++;
         if (k == 6) cpu_gpio_out = 32'h0;
         tick();
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] exp;
      logic [7:0]  first_sel;
      bit          seen;
      key_n = 4'b1011;
      repeat (4) tick();
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (cpu_gpio_in !== 32'h0) $display("FAIL midrst_gpio_in: got %h expected %h", cpu_gpio_in, 32'h0);
      else n_pass++;
      n_checks++;
      if (seg_n !== 7'h7F) $display("FAIL midrst_seg_n: got %h expected %h", seg_n, 7'h7F);
      else n_pass++;
      n_checks++;
      if (dig_sel_n !== 8'hFF) $display("FAIL midrst_dig_sel_n: got %h expected %h", dig_sel_n, 8'hFF);
      else n_pass++;
      repeat (2) tick();
      rst = 1'b1;
      seen      = 1'b0;
      first_sel = 8'hFF;
      for (int t = 1; t <= 7; t++) begin
         exp_in_q.push_back({10'h0, (t >= 7) ? 4'b0100 : 4'b0000, (t >= 3) ? SW_PAT : 18'h0});
         tick();
         exp = exp_in_q.pop_front();
         n_checks++;
         if (cpu_gpio_in !== exp) $display("FAIL midrst_key2 t=%0d: got %h expected %h", t, cpu_gpio_in, exp);
         else n_pass++;
         if (!seen && dig_sel_n !== 8'hFF) begin
            seen      = 1'b1;
            first_sel = dig_sel_n;
         end
      end
      n_checks++;
      if (!seen || first_sel !== 8'hFE) $display("FAIL midrst_scan_restart: got %h expected %h", first_sel, 8'hFE);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_switches();
      test_key_press();
      test_key_glitch();
      test_scan();
      test_midframe();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/gpio_periph.md
GPIO_PERIPH -- requirements
Module: gpio_periph

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles required to accept a key change.
REQ-002 SHALL have parameter SCAN_DIV, default 50000, the number of clocks each display digit is driven.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sw, input, 18 bits: raw board switches, asynchronous to clk.
REQ-006 SHALL have port key_n, input, 4 bits: raw pushbuttons, active-low, asynchronous, bouncy.
REQ-007 SHALL have port cpu_gpio_out, input, 32 bits: the CPU GPIO output word to be displayed.
REQ-008 SHALL have port cpu_gpio_in, output, 32 bits: the word the CPU samples as GPIO input.
REQ-009 SHALL have port seg_n, output, 7 bits: active-low segments {g,f,e,d,c,b,a} shared by all digits.
REQ-010 SHALL have port dig_sel_n, output, 8 bits: active-low digit enables, one-hot-low.

Function
REQ-011 SHALL pass sw and key_n each through a 2-flop synchronizer before any other use.
REQ-012 SHALL give each key its own debounce counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits wide.
REQ-013 SHALL clear a key's counter whenever its synchronized value equals its stable value.
REQ-014 SHALL increment a key's counter while its synchronized value differs from its stable value.
REQ-015 SHALL, on the cycle a key's counter reaches DEBOUNCE_CYCLES-1 with values still differing, update the stable value and clear the counter, so exactly DEBOUNCE_CYCLES consecutive differing cycles are needed.
REQ-016 SHALL restart counting from zero when a glitch shorter than DEBOUNCE_CYCLES returns to the stable value.
REQ-017 SHALL define key_pressed[i] = ~stable_key_n[i], active-high.
REQ-018 SHALL register cpu_gpio_in every cycle as {10'b0, key_pressed[3:0], sw_sync[17:0]}, bits [31:22] always 0.
REQ-019 SHALL clock a scan prescaler counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-020 SHALL advance a 3-bit digit index 0..7 (wrapping 7->0) on the prescaler wrap.
REQ-021 SHALL load a 32-bit snapshot register from cpu_gpio_out on the first clock after reset release and on every 7->0 digit-index wrap only, so one scan frame never shows a mixed word.
REQ-022 SHALL register the outputs so that dig_sel_n = ~(8'b1 << idx) and seg_n = hex7seg(snapshot[4*idx+3 : 4*idx]), one clock after idx changes.
REQ-023 SHALL decode hex7seg for all 16 values 0-F; F SHALL be 7'b0001110 (active-low g..a).
REQ-024 SHALL keep the prescaler and index free-running with no stall; changes to cpu_gpio_out mid-frame are ignored until the next wrap.

Reset
REQ-025 SHALL, while rst=0, set cpu_gpio_in=32'h0, seg_n=7'h7F (blank), dig_sel_n=8'hFF (all off), prescaler=0, idx=0, snapshot=0, counters=0.
REQ-026 SHALL reset key synchronizer and stable flops to 1 (released) and sw synchronizer flops to 0.
REQ-027 SHALL discard any in-progress debounce or partial scan when reset asserts mid-operation, restarting at idx=0 after release.

Structure
REQ-028 SHALL place NUM_DIGITS=8, SW_W=18, KEY_W=4, and the 16-entry segment-encoding table in package gpio_periph_pkg.
REQ-029 SHALL implement the nibble-to-segment decode as the combinational sub-module hex7seg, with 4-bit input and 7-bit active-low output.

Verification
REQ-030 (DEBOUNCE_CYCLES=4) key_n[0] held 1->0 -> cpu_gpio_in[18]=1 exactly 2 sync + 4 debounce + 1 output register = 7 clocks later.
REQ-031 (DEBOUNCE_CYCLES=4) key_n[1] pulsed low for 3 cycles -> cpu_gpio_in[19] stays 0.
REQ-032 sw=18'h2A5A5 static -> cpu_gpio_in=32'h0002A5A5 after 3 clocks.
REQ-033 (SCAN_DIV=2) cpu_gpio_out=32'h89ABCDEF -> digits 0..7 show F,E,D,C,B,A,9,8 with dig_sel_n 8'hFE,8'hFD,...,8'h7F, each held 2 clocks.
REQ-034 (SCAN_DIV=2) cpu_gpio_out changes to 32'h0 while idx=3 -> digits 3..7 keep old values; next frame shows 0 (seg_n=7'b1000000).
REQ-035 rst pulsed low mid-frame with key debounce in progress -> outputs return to reset values immediately; scan restarts at dig_sel_n=8'hFE.
